// File: rtl/sr_latch_pulse_scheduler_pkg.sv
// Shared state encoding and counter sizing for the SR latch pulse scheduler.
package sr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    RECOVER = 2'd2,
    VERIFY  = 2'd3
  } state_t;

  localparam int unsigned CNT_W_DEFAULT = 2;

  // Width of a counter that runs 0 .. max(pulse_cyc, rec_cyc)-1.
  function automatic int unsigned cnt_width(int unsigned pulse_cyc, int unsigned rec_cyc);
    int unsigned m;
    m = (pulse_cyc > rec_cyc) ? pulse_cyc : rec_cyc;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sr_latch_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import sr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Scan from the farthest offset down so the nearest offset to ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant                                = '0;
        grant[(int'(ptr) + k) % NUM_REQ]     = 1'b1;
        grant_idx                            = PTR_W'((int'(ptr) + k) % NUM_REQ);
        grant_any                            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_latch_pulse_scheduler.sv
// Time-multiplexes S/R pulses onto a bank of NOR SR latches for NUM_REQ requesters.
// Define SR_VERIFY_EN to add a post-recovery readback check of q_in driving a sticky err.
module sr_latch_pulse_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LATCH = 8,
  parameter int IDX_W     = 3,
  parameter int PULSE_CYC = 3,
  parameter int REC_CYC   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_set,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_LATCH-1:0]     s_out,
  output logic [NUM_LATCH-1:0]     r_out,
  input  logic [NUM_LATCH-1:0]     q_in,
  output logic                     busy,
  output logic                     err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = int'(cnt_width(PULSE_CYC, REC_CYC));

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [NUM_LATCH-1:0] s_q, s_d, r_q, r_d;
  logic [NUM_REQ-1:0]   ack_d;

  logic [NUM_REQ-1:0]   grant;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_set;
  logic                 sel_in_range;
  logic [NUM_LATCH-1:0] sel_hot;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_idx = '0;
    sel_set = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx = req_idx[i*IDX_W +: IDX_W];
        sel_set = req_set[i];
      end
    end
  end

  assign sel_in_range = (int'(sel_idx) < NUM_LATCH);

  generate
    for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_hot
      assign sel_hot[gi] = (int'(sel_idx) == gi);
    end
  endgenerate

`ifdef SR_VERIFY_EN
  localparam state_t REC_NEXT = VERIFY;

  logic [NUM_LATCH-1:0] sync1_q, sync2_q, hot_q;
  logic                 set_q, err_q;

  // q_in comes from the asynchronous latch array, hence the 2-flop synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hot_q   <= '0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= q_in;
      sync2_q <= sync1_q;
      if (state_q == IDLE && grant_any) begin
        hot_q <= sel_hot;
        set_q <= sel_set;
        if (!sel_in_range) err_q <= 1'b1;
      end
      if (state_q == VERIFY && ((|(sync2_q & hot_q)) != set_q)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  localparam state_t REC_NEXT = IDLE;

  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    s_d     = s_q;
    r_d     = r_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          ack_d = grant;
          rr_d  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          // An out-of-range target is acknowledged but never driven.
          if (sel_in_range) begin
            state_d = PULSE;
            cnt_d   = '0;
            s_d     = sel_set ? sel_hot : '0;
            r_d     = sel_set ? '0 : sel_hot;
          end
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d = RECOVER;
          cnt_d   = '0;
          s_d     = '0;
          r_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_q == CNT_W'(REC_CYC - 1)) begin
          state_d = REC_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      VERIFY:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      s_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign req_ack = rst ? '0 : ack_d;
  assign s_out   = s_q;
  assign r_out   = r_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sr_latch_pulse_scheduler.sv
// Randomized bench for sr_latch_pulse_scheduler against a timeline model of grants and pulse windows.
module tb_sr_latch_pulse_scheduler;
  localparam int NR = 4, NL = 8, IW = 3, P = 3, R = 2, NL6 = 6;
`ifdef SR_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_valid = '0, req_set = '0, req_ack;
  logic [NR*IW-1:0] req_idx = '0;
  logic [NL-1:0]    s_out, r_out, q_in;
  logic [NL-1:0]    q_lat = '0;
  logic             busy, err;
  logic [NR-1:0]    v6 = '0, set6 = '0, ack6;
  logic [NR*IW-1:0] idx6 = '0;
  logic [NL6-1:0]   s6, r6;
  logic [NL6-1:0]   q6 = '0;
  logic             busy6, err6;
  logic             force_q1 = 1'b0;

  int compared = 0, mismatched = 0, cyc = 0;
  int ptr, free_at, last_ack, pw_start, pw_end, pw_latch, err_from, err6_from;
  logic pw_set;
  logic [NR-1:0] ack_obs, ack6_obs;
  int last_r2, first_s2;

  always #5 clk = ~clk;

  // Behavioural NOR latch bank fed by the DUT drive; bit 1 can be stuck low.
  always @(s_out or r_out) q_lat = (q_lat | s_out) & ~r_out;
  assign q_in = force_q1 ? (q_lat & 8'hFD) : q_lat;

  sr_latch_pulse_scheduler #(.NUM_REQ(NR), .NUM_LATCH(NL), .IDX_W(IW), .PULSE_CYC(P), .REC_CYC(R)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set), .req_idx(req_idx),
    .req_ack(req_ack), .s_out(s_out), .r_out(r_out), .q_in(q_in), .busy(busy), .err(err));

  sr_latch_pulse_scheduler #(.NUM_REQ(NR), .NUM_LATCH(NL6), .IDX_W(IW), .PULSE_CYC(P), .REC_CYC(R)) dut6 (
    .clk(clk), .rst(rst), .req_valid(v6), .req_set(set6), .req_idx(idx6),
    .req_ack(ack6), .s_out(s6), .r_out(r6), .q_in(q6), .busy(busy6), .err(err6));

  task automatic model_reset();
    ptr = 0; free_at = 0; last_ack = -100; pw_start = -100; pw_end = -200;
    pw_latch = 0; pw_set = 1'b0; err_from = NEVER; err6_from = NEVER;
    ack_obs = '0; ack6_obs = '0; last_r2 = -1; first_s2 = -1;
  endtask

  // One clock: model the cycle, compare everything at negedge, advance.
  task automatic step();
    logic [NR-1:0] exp_ack;
    logic [NL-1:0] exp_s, exp_r;
    logic exp_busy, exp_err, exp_err6;
    int g, idx;
    @(negedge clk);
    exp_ack = '0;
    g = -1;
    if (cyc >= free_at)
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
    if (g >= 0) begin
      exp_ack[g] = 1'b1;
      ptr = (g + 1) % NR;
      last_ack = cyc;
      idx = int'(req_idx[g*IW +: IW]);
      if (idx < NL) begin
        pw_start = cyc + 1; pw_end = cyc + P; pw_latch = idx; pw_set = req_set[g];
        free_at = cyc + 1 + P + R + VER;
        if (VER == 1 && force_q1 && idx == 1 && req_set[g] && err_from > cyc + P + R + 2)
          err_from = cyc + P + R + 2;
      end else begin
        free_at = cyc + 1;
        if (VER == 1 && err_from > cyc + 1) err_from = cyc + 1;
      end
    end
    exp_s = '0;
    exp_r = '0;
    if (cyc >= pw_start && cyc <= pw_end) begin
      if (pw_set) exp_s[pw_latch] = 1'b1;
      else        exp_r[pw_latch] = 1'b1;
    end
    exp_busy = (cyc > last_ack) && (cyc < free_at);
    if (VER == 1 && v6 != '0 && err6_from > cyc + 1) err6_from = cyc + 1;
    exp_err  = (cyc >= err_from);
    exp_err6 = (cyc >= err6_from);

    compared++; if (req_ack !== exp_ack) begin mismatched++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, req_ack, exp_ack); end
    compared++; if (s_out !== exp_s) begin mismatched++; $display("FAIL s_out cyc=%0d got=%h exp=%h", cyc, s_out, exp_s); end
    compared++; if (r_out !== exp_r) begin mismatched++; $display("FAIL r_out cyc=%0d got=%h exp=%h", cyc, r_out, exp_r); end
    compared++; if (busy !== exp_busy) begin mismatched++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
    compared++; if (err !== exp_err) begin mismatched++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, exp_err); end
    compared++;
    if ((s_out & r_out) != '0 || $countones(s_out | r_out) > 1) begin
      mismatched++; $display("FAIL sr_excl cyc=%0d s=%h r=%h", cyc, s_out, r_out);
    end
    compared++; if (ack6 !== v6) begin mismatched++; $display("FAIL ack6 cyc=%0d got=%b exp=%b", cyc, ack6, v6); end
    compared++;
    if ((s6 | r6) !== '0 || busy6 !== 1'b0) begin
      mismatched++; $display("FAIL oob_drive cyc=%0d s6=%h r6=%h busy6=%b exp=0", cyc, s6, r6, busy6);
    end
    compared++; if (err6 !== exp_err6) begin mismatched++; $display("FAIL err6 cyc=%0d got=%b exp=%b", cyc, err6, exp_err6); end

    if (r_out[2]) last_r2 = cyc;
    if (s_out[2] && first_s2 < 0) first_s2 = cyc;
    ack_obs  = req_ack;
    ack6_obs = ack6;
    $display("cyc=%0d valid=%b ack=%b s=%h r=%h busy=%b err=%b", cyc, req_valid, req_ack, s_out, r_out, busy, err);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    req_valid = '0; v6 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc += 2;
    model_reset();
  endtask

  task automatic serve(input int i, input logic s, input int idx, input int extra);
    int n;
    req_valid[i] = 1'b1; req_set[i] = s; req_idx[i*IW +: IW] = IW'(idx);
    ack_obs = '0;
    n = 0;
    while (!ack_obs[i] && n < 20) begin step(); n++; end
    compared++;
    if (!ack_obs[i]) begin mismatched++; $display("FAIL serve_timeout req=%0d got=no_ack exp=ack", i); end
    req_valid[i] = 1'b0;
    repeat (extra) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; req_set = 4'b0101; v6 = '0;
    @(negedge clk);
    compared++;
    if (req_ack !== '0 || s_out !== '0 || r_out !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      mismatched++; $display("FAIL reset_outputs got ack=%b s=%h r=%h busy=%b err=%b exp=all0", req_ack, s_out, r_out, busy, err);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    serve(0, 1'b1, 5, 8);
  endtask

  task automatic test_all_valid();
    int gidx[$];
    int gcyc[$];
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_set[i] = 1'($urandom_range(1, 0)); req_idx[i*IW +: IW] = IW'($urandom_range(NL - 1, 0));
    end
    req_valid = '1;
    for (int n = 0; n < 28; n++) begin
      step();
      for (int i = 0; i < NR; i++) if (ack_obs[i]) begin
        gidx.push_back(i); gcyc.push_back(cyc - 1);
        req_set[i] = 1'($urandom_range(1, 0)); req_idx[i*IW +: IW] = IW'($urandom_range(NL - 1, 0));
      end
    end
    req_valid = '0;
    repeat (7) step();
    compared++;
    if (gidx.size() < 5) begin mismatched++; $display("FAIL rr_count got=%0d exp>=5", gidx.size()); end
    else for (int n = 0; n < 5; n++) begin
      compared++;
      if (gidx[n] != n % NR) begin mismatched++; $display("FAIL rr_order n=%0d got=%0d exp=%0d", n, gidx[n], n % NR); end
      if (n > 0) begin
        compared++;
        if (gcyc[n] - gcyc[n-1] != 1 + P + R + VER) begin
          mismatched++; $display("FAIL rr_spacing n=%0d got=%0d exp=%0d", n, gcyc[n] - gcyc[n-1], 1 + P + R + VER);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_set[1] = 1'b0; req_idx[1*IW +: IW] = 3'd2;
    req_set[2] = 1'b1; req_idx[2*IW +: IW] = 3'd2;
    req_valid = 4'b0110;
    for (int n = 0; n < 20; n++) begin
      step();
      req_valid = req_valid & ~ack_obs;
    end
    compared++;
    if (last_r2 < 0 || first_s2 < 0 || first_s2 - last_r2 < R + 1) begin
      mismatched++; $display("FAIL b2b_gap got r_last=%0d s_first=%0d exp_gap>=%0d", last_r2, first_s2, R + 1);
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    serve(3, 1'b1, 6, 1);
    rst = 1'b1;
    #1;
    compared++;
    if (s_out !== '0 || r_out !== '0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL async_reset got s=%h r=%h busy=%b exp=0", s_out, r_out, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cyc += 1;
    model_reset();
    serve(2, 1'b0, 4, 8);
  endtask

  task automatic test_verify();
    do_reset();
    force_q1 = 1'b1;
    serve(0, 1'b1, 1, 10);
    compared++;
    if (err !== 1'(VER)) begin mismatched++; $display("FAIL verify_forced got=%b exp=%b", err, 1'(VER)); end
    do_reset();
    force_q1 = 1'b0;
    serve(0, 1'b1, 1, 10);
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL verify_clean got=%b exp=0", err); end
  endtask

  task automatic test_out_of_range();
    int n;
    do_reset();
    set6[0] = 1'b1; idx6[0 +: IW] = 3'd7;
    v6[0] = 1'b1;
    n = 0;
    ack6_obs = '0;
    while (!ack6_obs[0] && n < 10) begin step(); n++; end
    compared++;
    if (!ack6_obs[0]) begin mismatched++; $display("FAIL oob_ack got=no_ack exp=ack"); end
    v6 = '0;
    repeat (8) step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (ack_obs[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(99, 0) < 30);
          req_set[i]   = 1'($urandom_range(1, 0));
          req_idx[i*IW +: IW] = IW'($urandom_range(NL - 1, 0));
        end else if ($urandom_range(99, 0) < 5) begin
          req_set[i] = 1'($urandom_range(1, 0));
          req_idx[i*IW +: IW] = IW'($urandom_range(NL - 1, 0));
        end else if ($urandom_range(99, 0) < 3) begin
          req_valid[i] = 1'b0;
        end
      end
      step();
    end
    req_valid = '0;
    repeat (8) step();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_back_to_back();
    test_reset_mid_pulse();
    test_verify();
    test_out_of_range();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
